// File: rtl/lsu_sram_req_pkg.sv
// Shared definitions for the LSU data-bus initiator: memop codes, bus sizes, FSM states.
// LSU_LWLR_EN adds LWL/LWR to the set of load operations.
package lsu_sram_req_pkg;

  localparam int MMOP_W = 4;

  typedef enum logic [MMOP_W-1:0] {
    MOP_NOP = 4'd0,
    MOP_LB  = 4'd1,
    MOP_LBU = 4'd2,
    MOP_LH  = 4'd3,
    MOP_LHU = 4'd4,
    MOP_LW  = 4'd5,
    MOP_SB  = 4'd6,
    MOP_SH  = 4'd7,
    MOP_SW  = 4'd8,
    MOP_LWL = 4'd9,
    MOP_LWR = 4'd10
  } memop_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE,
    ST_CANCEL
  } state_e;

  function automatic logic is_load(input logic [MMOP_W-1:0] op);
    case (op)
      MOP_LB, MOP_LBU, MOP_LH, MOP_LHU, MOP_LW: is_load = 1'b1;
`ifdef LSU_LWLR_EN
      MOP_LWL, MOP_LWR:                         is_load = 1'b1;
`endif
      default:                                  is_load = 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [MMOP_W-1:0] op);
    case (op)
      MOP_SB, MOP_SH, MOP_SW: is_store = 1'b1;
      default:                is_store = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] op_size(input logic [MMOP_W-1:0] op);
    case (op)
      MOP_LB, MOP_LBU, MOP_SB: op_size = SZ_B;
      MOP_LH, MOP_LHU, MOP_SH: op_size = SZ_H;
      default:                 op_size = SZ_W;
    endcase
  endfunction

  // LWL/LWR are unaligned by design and never fault.
  function automatic logic misaligned(input logic [MMOP_W-1:0] op, input logic [1:0] lo);
    case (op)
      MOP_LH, MOP_LHU, MOP_SH: misaligned = lo[0];
      MOP_LW, MOP_SW:          misaligned = |lo;
      default:                 misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load formatter: selects the addressed lane and sign/zero-extends it.
// With LSU_LWLR_EN defined, also merges LWL/LWR results into the old rt value.
module lsu_load_align
  import lsu_sram_req_pkg::*;
(
  input  logic [MMOP_W-1:0] i_op,
  input  logic [1:0]        i_off,
  input  logic [31:0]       i_rdata,
  input  logic [31:0]       i_rt,
  output logic [31:0]       o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

`ifdef LSU_LWLR_EN
  logic [4:0] w_shl;
  logic [4:0] w_shr;
  assign w_shl = {2'd3 - i_off, 3'b000};
  assign w_shr = {i_off, 3'b000};
`else
  logic w_unused_rt;
  assign w_unused_rt = ^i_rt;
`endif

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    w_byte = i_rdata[8*i_off +: 8];
    w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_data = '0;
    case (i_op)
      MOP_LB:  o_data = {{24{w_byte[7]}}, w_byte};
      MOP_LBU: o_data = {24'h0, w_byte};
      MOP_LH:  o_data = {{16{w_half[15]}}, w_half};
      MOP_LHU: o_data = {16'h0, w_half};
      MOP_LW:  o_data = i_rdata;
`ifdef LSU_LWLR_EN
      MOP_LWL: o_data = (i_rdata << w_shl) | (i_rt & ~(32'hFFFF_FFFF << w_shl));
      MOP_LWR: o_data = (i_rdata >> w_shr) | (i_rt & ~(32'hFFFF_FFFF >> w_shr));
`endif
      default: o_data = '0;
    endcase
  end

endmodule

// File: rtl/lsu_sram_req.sv
// Data-side SRAM-like bus initiator between EX and MEM; one outstanding transaction.
// Defining LSU_LWLR_EN enables LWL/LWR; otherwise those codes are no-ops.
module lsu_sram_req
  import lsu_sram_req_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid_i,
  input  logic [3:0]        ex_memop_i,
  input  logic [ADDR_W-1:0] ex_addr_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  input  logic [DATA_W-1:0] ex_rt_i,
  input  logic              flush_i,
  input  logic              mem_stall_i,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_rvalid_o,
  output logic              adel_o,
  output logic              ades_o,
  output logic              lsu_stall_o
);

  if (DATA_W != 32) begin : g_bad_data_w
    $error("lsu_sram_req: DATA_W must be 32");
  end

  state_e              r_state, w_next;
  logic [MMOP_W-1:0]   r_op;
  logic [1:0]          r_off;
  logic [ADDR_W-1:0]   r_addr;
  logic [1:0]          r_size;
  logic                r_wr;
  logic                r_kill;
  logic [DATA_W-1:0]   r_wdata, r_rt, r_result;

  logic                w_is_load, w_is_store, w_misalign, w_lwlr, w_launch;
  logic [1:0]          w_size;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata, w_fmt;

  always_comb begin
    w_is_load  = ex_valid_i && is_load(ex_memop_i);
    w_is_store = ex_valid_i && is_store(ex_memop_i);
    w_misalign = misaligned(ex_memop_i, ex_addr_i[1:0]);
`ifdef LSU_LWLR_EN
    w_lwlr     = (ex_memop_i == MOP_LWL) || (ex_memop_i == MOP_LWR);
`else
    w_lwlr     = 1'b0;
`endif
    w_launch   = (r_state == ST_IDLE) && (w_is_load || w_is_store) && !w_misalign && !flush_i;
    w_size     = op_size(ex_memop_i);
    w_addr     = ex_addr_i;
    if (w_lwlr) w_addr[1:0] = 2'b00;
    case (ex_memop_i)
      MOP_SB:  w_wdata = {4{ex_wdata_i[7:0]}};
      MOP_SH:  w_wdata = {2{ex_wdata_i[15:0]}};
      MOP_SW:  w_wdata = ex_wdata_i;
      default: w_wdata = '0;
    endcase
  end

  assign adel_o = w_is_load  && w_misalign;
  assign ades_o = w_is_store && w_misalign;

  lsu_load_align u_align (
    .i_op    (r_op),
    .i_off   (r_off),
    .i_rdata (data_rdata),
    .i_rt    (r_rt),
    .o_data  (w_fmt)
  );

  always_comb begin
    w_next       = r_state;
    data_req     = 1'b0;
    data_wr      = 1'b0;
    data_size    = SZ_B;
    data_addr    = '0;
    data_wdata   = '0;
    lsu_stall_o  = 1'b0;
    mem_rvalid_o = 1'b0;
    mem_rdata_o  = '0;
    unique case (r_state)
      ST_IDLE: if (w_launch) begin
        w_next      = data_addr_ok ? ST_WAIT : ST_REQ;
        data_req    = 1'b1;
        data_wr     = w_is_store;
        data_size   = w_size;
        data_addr   = w_addr;
        data_wdata  = w_wdata;
        lsu_stall_o = 1'b1;
      end
      ST_REQ: begin
        // A flushed request must still complete its address phase before being dropped.
        data_req    = 1'b1;
        data_wr     = r_wr;
        data_size   = r_size;
        data_addr   = r_addr;
        data_wdata  = r_wdata;
        lsu_stall_o = 1'b1;
        if (data_addr_ok) w_next = (r_kill || flush_i) ? ST_CANCEL : ST_WAIT;
      end
      ST_WAIT: begin
        lsu_stall_o = 1'b1;
        if (data_data_ok) w_next = flush_i ? ST_IDLE : ST_DONE;
        else if (flush_i) w_next = ST_CANCEL;
      end
      ST_DONE: begin
        if (flush_i) begin
          w_next = ST_IDLE;
        end else begin
          mem_rvalid_o = 1'b1;
          mem_rdata_o  = r_result;
          if (!mem_stall_i) w_next = ST_IDLE;
        end
      end
      ST_CANCEL: if (data_data_ok) w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_op     <= '0;
      r_off    <= '0;
      r_addr   <= '0;
      r_size   <= '0;
      r_wr     <= 1'b0;
      r_kill   <= 1'b0;
      r_wdata  <= '0;
      r_rt     <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_next;
      if (w_launch) begin
        r_op    <= ex_memop_i;
        r_off   <= ex_addr_i[1:0];
        r_addr  <= w_addr;
        r_size  <= w_size;
        r_wr    <= w_is_store;
        r_wdata <= w_wdata;
        r_rt    <= ex_rt_i;
        r_kill  <= 1'b0;
      end else if (r_state == ST_REQ && flush_i) begin
        r_kill  <= 1'b1;
      end
      if (r_state == ST_WAIT && data_data_ok && !flush_i)
        r_result <= r_wr ? '0 : w_fmt;
    end
  end

endmodule

// File: tb/tb_lsu_sram_req.sv
// Self-checking bench for lsu_sram_req: directed bus scenarios plus randomized ops
// checked against an arithmetic reference model. Honours LSU_LWLR_EN when defined.
module tb_lsu_sram_req;
  import lsu_sram_req_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid_i, flush_i, mem_stall_i;
  logic [3:0]  ex_memop_i;
  logic [31:0] ex_addr_i, ex_wdata_i, ex_rt_i;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata, mem_rdata_o;
  logic        mem_rvalid_o, adel_o, ades_o, lsu_stall_o;

  int n_tests = 0;
  int n_fail  = 0;

  lsu_sram_req dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid_i   (ex_valid_i),
    .ex_memop_i   (ex_memop_i),
    .ex_addr_i    (ex_addr_i),
    .ex_wdata_i   (ex_wdata_i),
    .ex_rt_i      (ex_rt_i),
    .flush_i      (flush_i),
    .mem_stall_i  (mem_stall_i),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .mem_rdata_o  (mem_rdata_o),
    .mem_rvalid_o (mem_rvalid_o),
    .adel_o       (adel_o),
    .ades_o       (ades_o),
    .lsu_stall_o  (lsu_stall_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got running, expected done)");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic check_b(input string tag, input logic obs, input logic exp);
    check(tag, {31'b0, obs}, {31'b0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model (from the op table, plain arithmetic) ----------------
  function automatic logic m_lwlr_on();
`ifdef LSU_LWLR_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic m_is_load(input logic [3:0] op);
    return (op >= 4'd1 && op <= 4'd5) || (m_lwlr_on() && (op == 4'd9 || op == 4'd10));
  endfunction

  function automatic logic m_is_mem(input logic [3:0] op);
    return m_is_load(op) || (op >= 4'd6 && op <= 4'd8);
  endfunction

  function automatic logic m_misal(input logic [3:0] op, input logic [31:0] a);
    if (op inside {4'd3, 4'd4, 4'd7}) return (a % 2) != 0;
    if (op inside {4'd5, 4'd8})       return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_size(input logic [3:0] op);
    if (op inside {4'd1, 4'd2, 4'd6}) return 32'd0;
    if (op inside {4'd3, 4'd4, 4'd7}) return 32'd1;
    return 32'd2;
  endfunction

  function automatic logic [31:0] m_addr(input logic [3:0] op, input logic [31:0] a);
    return (op == 4'd9 || op == 4'd10) ? (a / 4) * 4 : a;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] wd);
    if (op == 4'd6) return (wd & 32'hFF) * 32'h0101_0101;
    if (op == 4'd7) return (wd & 32'hFFFF) * 32'h0001_0001;
    if (op == 4'd8) return wd;
    return 32'h0;
  endfunction

  function automatic logic [31:0] m_result(input logic [3:0] op, input int off,
                                           input logic [31:0] rd, input logic [31:0] rt);
    logic [31:0] b, h;
    b = (rd >> (8 * off)) & 32'hFF;
    h = (rd >> ((off >= 2) ? 16 : 0)) & 32'hFFFF;
    case (op)
      4'd1:    return (b >= 128)   ? (b | 32'hFFFF_FF00) : b;
      4'd2:    return b;
      4'd3:    return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      4'd4:    return h;
      4'd5:    return rd;
      4'd9:    return (rd << (8 * (3 - off))) | (rt & ~(32'hFFFF_FFFF << (8 * (3 - off))));
      4'd10:   return (rd >> (8 * off)) | (rt & ~(32'hFFFF_FFFF >> (8 * off)));
      default: return 32'h0;
    endcase
  endfunction

  // One complete op: launch, aok REQ cycles, dok WAIT cycles, hold DONE stall cycles.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rt, input logic [31:0] rd,
                        input int aok, input int dok, input int hold);
    logic mem, ld, mis;
    logic [31:0] exp_res;
    mem = m_is_mem(op);
    ld  = m_is_load(op);
    mis = mem && m_misal(op, addr);
    ex_valid_i = 1'b1; ex_memop_i = op; ex_addr_i = addr; ex_wdata_i = wd; ex_rt_i = rt;
    data_addr_ok = (aok == 0);
    @(negedge clk);
    check_b({tag, " adel"}, adel_o, mis && ld);
    check_b({tag, " ades"}, ades_o, mis && !ld);
    if (!mem || mis) begin
      check_b({tag, " noreq"}, data_req, 1'b0);
      check_b({tag, " nostall"}, lsu_stall_o, 1'b0);
      tick();
      ex_valid_i = 1'b0; data_addr_ok = 1'b0;
      @(negedge clk);
      check_b({tag, " idle rvalid"}, mem_rvalid_o, 1'b0);
      check_b({tag, " idle req"}, data_req, 1'b0);
      tick();
      return;
    end
    check_b({tag, " req"}, data_req, 1'b1);
    check_b({tag, " stall"}, lsu_stall_o, 1'b1);
    check_b({tag, " wr"}, data_wr, !ld);
    check({tag, " size"}, {30'b0, data_size}, m_size(op));
    check({tag, " addr"}, data_addr, m_addr(op, addr));
    check({tag, " wdata"}, data_wdata, m_wdata(op, wd));
    tick();
    ex_valid_i = 1'b0; ex_memop_i = 4'd0;
    ex_addr_i = $urandom; ex_wdata_i = $urandom; ex_rt_i = $urandom;
    for (int k = 1; k <= aok; k++) begin
      data_addr_ok = (k == aok);
      @(negedge clk);
      check_b({tag, " hold req"}, data_req, 1'b1);
      check_b({tag, " hold stall"}, lsu_stall_o, 1'b1);
      check_b({tag, " hold wr"}, data_wr, !ld);
      check({tag, " hold size"}, {30'b0, data_size}, m_size(op));
      check({tag, " hold addr"}, data_addr, m_addr(op, addr));
      check({tag, " hold wdata"}, data_wdata, m_wdata(op, wd));
      tick();
    end
    data_addr_ok = 1'b0;
    for (int j = 1; j <= dok; j++) begin
      data_data_ok = (j == dok);
      data_rdata   = (j == dok) ? rd : $urandom;
      mem_stall_i  = (j == dok) && (hold > 0);
      @(negedge clk);
      check_b({tag, " wait req"}, data_req, 1'b0);
      check_b({tag, " wait stall"}, lsu_stall_o, 1'b1);
      check_b({tag, " wait rvalid"}, mem_rvalid_o, 1'b0);
      tick();
    end
    data_data_ok = 1'b0; data_rdata = $urandom;
    exp_res = m_result(op, int'(addr % 4), rd, rt);
    for (int h = 0; h <= hold; h++) begin
      mem_stall_i = (h < hold);
      @(negedge clk);
      check_b({tag, " done stall"}, lsu_stall_o, 1'b0);
      if (ld) begin
        check_b({tag, " rvalid"}, mem_rvalid_o, 1'b1);
        check({tag, " rdata"}, mem_rdata_o, exp_res);
      end
      tick();
    end
    mem_stall_i = 1'b0;
    @(negedge clk);
    check_b({tag, " after rvalid"}, mem_rvalid_o, 1'b0);
    check_b({tag, " after stall"}, lsu_stall_o, 1'b0);
    tick();
  endtask

  task automatic launch_lw(input logic [31:0] addr, input logic aok);
    ex_valid_i = 1'b1; ex_memop_i = 4'd5; ex_addr_i = addr;
    data_addr_ok = aok;
    tick();
    ex_valid_i = 1'b0; ex_memop_i = 4'd0; data_addr_ok = 1'b0;
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a;
    rst = 1'b1;
    ex_valid_i = 1'b0; ex_memop_i = '0; ex_addr_i = '0; ex_wdata_i = '0; ex_rt_i = '0;
    flush_i = 1'b0; mem_stall_i = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
    repeat (2) @(negedge clk);
    check_b("rst req", data_req, 1'b0);
    check_b("rst wr", data_wr, 1'b0);
    check("rst size", {30'b0, data_size}, 32'h0);
    check("rst addr", data_addr, 32'h0);
    check("rst wdata", data_wdata, 32'h0);
    check("rst rdata", mem_rdata_o, 32'h0);
    check_b("rst rvalid", mem_rvalid_o, 1'b0);
    check_b("rst adel", adel_o, 1'b0);
    check_b("rst ades", ades_o, 1'b0);
    check_b("rst stall", lsu_stall_o, 1'b0);
    @(posedge clk); #1; rst = 1'b0;
    tick();

    // Directed scenarios
    run_op("lw",   4'd5, 32'h1000, 32'h0, 32'h0, 32'hDEAD_BEEF, 0, 2, 0);
    run_op("lb",   4'd1, 32'h1003, 32'h0, 32'h0, 32'h8011_2233, 0, 1, 0);
    run_op("lbu",  4'd2, 32'h1003, 32'h0, 32'h0, 32'h8011_2233, 1, 1, 0);
    run_op("lhu",  4'd4, 32'h1002, 32'h0, 32'h0, 32'h8011_2233, 0, 1, 0);
    run_op("lh",   4'd3, 32'h1000, 32'h0, 32'h0, 32'h1234_F00D, 0, 1, 2);
    run_op("sh",   4'd7, 32'h2002, 32'h0000_ABCD, 32'h0, 32'h0, 3, 1, 0);
    run_op("sb",   4'd6, 32'h2001, 32'h1234_5678, 32'h0, 32'h0, 1, 2, 0);
    run_op("lwmis", 4'd5, 32'h1001, 32'h0, 32'h0, 32'h0, 0, 1, 0);
    run_op("swmis", 4'd8, 32'h1002, 32'h0, 32'h0, 32'h0, 0, 1, 0);
    run_op("lwl",  4'd9,  32'h1001, 32'h0, 32'hAABB_CCDD, 32'h1122_3344, 0, 1, 0);
    run_op("lwr",  4'd10, 32'h1001, 32'h0, 32'hAABB_CCDD, 32'h1122_3344, 1, 1, 0);

    // Flush while waiting for data; CANCEL drains the late response.
    launch_lw(32'h1000, 1'b1);
    flush_i = 1'b1;
    @(negedge clk);
    check_b("fwait stall", lsu_stall_o, 1'b1);
    check_b("fwait req", data_req, 1'b0);
    tick();
    flush_i = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h1234_5678;
    @(negedge clk);
    check_b("cancel rvalid", mem_rvalid_o, 1'b0);
    check("cancel rdata", mem_rdata_o, 32'h0);
    check_b("cancel stall", lsu_stall_o, 1'b0);
    tick();
    @(negedge clk);
    check_b("stray dok rvalid", mem_rvalid_o, 1'b0);
    tick();
    data_data_ok = 1'b0;
    @(negedge clk);
    check_b("post cancel rvalid", mem_rvalid_o, 1'b0);
    tick();
    run_op("lw after cancel", 4'd5, 32'h3000, 32'h0, 32'h0, 32'hCAFE_F00D, 0, 1, 0);

    // Flush during REQ: request stays up until accepted, then the response is dropped.
    launch_lw(32'h1004, 1'b0);
    flush_i = 1'b1;
    @(negedge clk);
    check_b("freq req", data_req, 1'b1);
    check("freq addr", data_addr, 32'h1004);
    tick();
    flush_i = 1'b0; data_addr_ok = 1'b1;
    @(negedge clk);
    check_b("freq req2", data_req, 1'b1);
    tick();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h5555_AAAA;
    @(negedge clk);
    check_b("freq cancel req", data_req, 1'b0);
    check_b("freq cancel rvalid", mem_rvalid_o, 1'b0);
    tick();
    data_data_ok = 1'b0;
    @(negedge clk);
    check_b("freq idle rvalid", mem_rvalid_o, 1'b0);
    tick();

    // Flush in DONE suppresses the result.
    launch_lw(32'h1008, 1'b1);
    data_data_ok = 1'b1; data_rdata = 32'h0BAD_CAFE;
    tick();
    data_data_ok = 1'b0; flush_i = 1'b1; mem_stall_i = 1'b1;
    @(negedge clk);
    check_b("fdone rvalid", mem_rvalid_o, 1'b0);
    check("fdone rdata", mem_rdata_o, 32'h0);
    tick();
    flush_i = 1'b0; mem_stall_i = 1'b0;
    @(negedge clk);
    check_b("fdone idle rvalid", mem_rvalid_o, 1'b0);
    tick();

    // Flush coinciding with data_ok in WAIT goes straight to IDLE.
    launch_lw(32'h100C, 1'b1);
    flush_i = 1'b1; data_data_ok = 1'b1;
    tick();
    flush_i = 1'b0; data_data_ok = 1'b0;
    @(negedge clk);
    check_b("fwait+dok rvalid", mem_rvalid_o, 1'b0);
    check_b("fwait+dok stall", lsu_stall_o, 1'b0);
    tick();
    run_op("lw after fdok", 4'd5, 32'h4000, 32'h0, 32'h0, 32'h0F0F_0F0F, 2, 1, 1);

    // Randomized ops against the reference model
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 10));
      a  = $urandom;
      if ($urandom_range(0, 1) == 1) a = (a / 4) * 4 + 32'($urandom_range(0, 3) & 2);
      run_op("rand", op, a, $urandom, $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(1, 3), $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
